p405s_trc_rcv: RTL and testbench

Trace-port receiver for the 405 core: the far end of the trace status (TS) and execution status (ES) buses driven by the core trace unit. It deserializes 12-nibble trace packets into address, type and timestamp records, buffers them in a small first-word-fall-through FIFO with a valid/ready handshake to the debug capture logic, and keeps saturating execution-event counters from the paired even/odd ES buses. It sits in the debug/trace subsystem, directly on the registered TRC_* trace outputs.

---
 rtl/p405s_trc_rcv.sv | 218 +++++++++++++++++++++
 tb/tb_p405s_trc_rcv.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_trc_rcv.sv
// 405 trace-port receiver: deserializes TS nibble packets into a FWFT
// record FIFO and counts execution events from the even/odd ES buses.
module p405s_trc_rcv #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             CB,
  input  logic             coreResetN,
  input  logic [0:3]       TRC_tsBusL2,
  input  logic [0:1]       TRC_evenESBusL2,
  input  logic [0:1]       TRC_oddESBusL2,
  input  logic             TRC_oddCycleL2,
  input  logic             RCV_clrStatus,
  input  logic             RCV_pktReady,
  output logic             RCV_pktValid,
  output logic [0:29]      RCV_pktData,
  output logic [0:1]       RCV_pktType,
  output logic [0:8]       RCV_pktStamp,
  output logic             RCV_pktErr,
  output logic             RCV_busy,
  output logic             RCV_overflow,
  output logic [0:CNT_W-1] RCV_instCnt,
  output logic [0:CNT_W-1] RCV_brCnt,
  output logic [0:CNT_W-1] RCV_excCnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = 42;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_STAMP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [39:0] sr_q, sr_d;
  logic [1:0]  type_q, type_d;
  logic        rec_push;

  logic [3:0]  nib;
  logic [43:0] rec_raw;
  logic [RW-1:0] rec;

  assign nib     = TRC_tsBusL2;
  assign rec_raw = {sr_q, nib};
  assign rec     = {rec_raw[43:14], type_q, rec_raw[8:0],
                    (|rec_raw[13:12]) | (|rec_raw[11:9])};

  always_ff @(posedge CB) begin
    if (!coreResetN) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      sr_q    <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      sr_q    <= sr_d;
      type_q  <= type_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    sr_d     = sr_q;
    type_d   = type_q;
    rec_push = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (nib[3]) begin
          type_d  = nib[2:1];
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        sr_d = {sr_q[35:0], nib};
        if (beat_q == 4'd7) begin
          beat_d  = '0;
          state_d = S_STAMP;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      S_STAMP: begin
        sr_d = {sr_q[35:0], nib};
        if (beat_q == 4'd2) begin
          rec_push = 1'b1;
          beat_d   = '0;
          state_d  = S_IDLE;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RCV_busy = (state_q != S_IDLE);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [RW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          empty, full, pop, push_ok, drop;
  logic [RW-1:0] head;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && RCV_pktReady;
  assign push_ok = rec_push && (!full || pop);
  assign drop    = rec_push && full && !pop;

  always_ff @(posedge CB) begin
    if (!coreResetN) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge CB) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= rec;
  end

  assign head         = mem_q[rd_q[AW-1:0]];
  assign RCV_pktValid = !empty;
  assign RCV_pktData  = empty ? '0 : head[41:12];
  assign RCV_pktType  = empty ? '0 : head[11:10];
  assign RCV_pktStamp = empty ? '0 : head[9:1];
  assign RCV_pktErr   = empty ? 1'b0 : head[0];

  logic [1:0] ev, od;
  logic [1:0] inc_inst, inc_br, inc_exc;
  logic       e_i, e_b, e_x, o_i, o_b, o_x;

  assign ev = TRC_evenESBusL2;
  assign od = TRC_oddESBusL2;

  always_comb begin
    e_i = 1'b0;
    e_b = 1'b0;
    e_x = 1'b0;
    unique case (1'b1)
      (ev == 2'b01): e_i = 1'b1;
      (ev == 2'b10): begin e_i = 1'b1; e_b = 1'b1; end
      (ev == 2'b11): e_x = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    o_i = 1'b0;
    o_b = 1'b0;
    o_x = 1'b0;
    unique case (1'b1)
      (od == 2'b01): o_i = 1'b1;
      (od == 2'b10): begin o_i = 1'b1; o_b = 1'b1; end
      (od == 2'b11): o_x = 1'b1;
      default: ;
    endcase
  end

  assign inc_inst = TRC_oddCycleL2 ? ({1'b0, e_i} + {1'b0, o_i}) : 2'd0;
  assign inc_br   = TRC_oddCycleL2 ? ({1'b0, e_b} + {1'b0, o_b}) : 2'd0;
  assign inc_exc  = TRC_oddCycleL2 ? ({1'b0, e_x} + {1'b0, o_x}) : 2'd0;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] c,
    input logic [1:0]       inc
  );
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] inst_q, br_q, exc_q;
  logic [CNT_W-1:0] inst_d, br_d, exc_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    inst_d = sat_add(inst_q, inc_inst);
    br_d   = sat_add(br_q, inc_br);
    exc_d  = sat_add(exc_q, inc_exc);
    ovf_d  = ovf_q | drop;
    if (RCV_clrStatus) begin
      inst_d = '0;
      br_d   = '0;
      exc_d  = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge CB) begin
    if (!coreResetN) begin
      inst_q <= '0;
      br_q   <= '0;
      exc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      inst_q <= inst_d;
      br_q   <= br_d;
      exc_q  <= exc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign RCV_overflow = ovf_q;
  assign RCV_instCnt  = inst_q;
  assign RCV_brCnt    = br_q;
  assign RCV_excCnt   = exc_q;

endmodule

// File: tb/tb_p405s_trc_rcv.sv
// Randomized and directed bench for p405s_trc_rcv against a
// queue-based packet/counter reference model.
module tb_p405s_trc_rcv;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int CMAX  = 65535;

  logic          clk = 1'b0;
  logic          rstn;
  logic [0:3]    ts;
  logic [0:1]    ev, od;
  logic          oc, clr, rdy;
  logic          vld, err, busy, ovf;
  logic [0:29]   dat;
  logic [0:1]    typ;
  logic [0:8]    stp;
  logic [0:CW-1] icnt, bcnt, xcnt;

  always #5 clk = ~clk;

  p405s_trc_rcv #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .CB(clk), .coreResetN(rstn),
    .TRC_tsBusL2(ts),
    .TRC_evenESBusL2(ev), .TRC_oddESBusL2(od),
    .TRC_oddCycleL2(oc),
    .RCV_clrStatus(clr), .RCV_pktReady(rdy),
    .RCV_pktValid(vld), .RCV_pktData(dat),
    .RCV_pktType(typ), .RCV_pktStamp(stp),
    .RCV_pktErr(err), .RCV_busy(busy),
    .RCV_overflow(ovf),
    .RCV_instCnt(icnt), .RCV_brCnt(bcnt),
    .RCV_excCnt(xcnt)
  );

  typedef struct packed {
    logic [29:0] d;
    logic [1:0]  t;
    logic [8:0]  s;
    logic        e;
  } rec_t;

  rec_t        mq[$];
  int          m_rem;
  logic [43:0] m_sr;
  logic [1:0]  m_type;
  bit          m_ovf;
  int          m_inst, m_br, m_exc;
  int          n_chk, n_pass;
  bit          rnd;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int n_of(input logic [1:0] c, input int k);
    // k: 0 instruction, 1 branch, 2 exception
    if (k == 0) return (c == 2'b01 || c == 2'b10) ? 1 : 0;
    if (k == 1) return (c == 2'b10) ? 1 : 0;
    return (c == 2'b11) ? 1 : 0;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rem  = 0;
    m_sr   = '0;
    m_type = '0;
    m_ovf  = 0;
    m_inst = 0;
    m_br   = 0;
    m_exc  = 0;
  endtask

  task automatic model_update();
    logic [3:0] n;
    bit   pop, push;
    rec_t r;
    n = ts;
    if (!rstn) begin
      model_reset();
      return;
    end
    pop  = (mq.size() > 0) && rdy;
    push = 0;
    r    = '0;
    if (m_rem == 0) begin
      if (n[3]) begin
        m_type = n[2:1];
        m_rem  = 11;
      end
    end else begin
      m_sr = {m_sr[39:0], n};
      m_rem--;
      if (m_rem == 0) begin
        push = 1;
        r.d = m_sr[43:14];
        r.t = m_type;
        r.s = m_sr[8:0];
        r.e = (m_sr[13:12] != 0) || (m_sr[11:9] != 0);
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1;
    end
    if (clr) begin
      m_inst = 0;
      m_br   = 0;
      m_exc  = 0;
      m_ovf  = 0;
    end else if (oc) begin
      m_inst = sat(m_inst + n_of(ev, 0) + n_of(od, 0));
      m_br   = sat(m_br + n_of(ev, 1) + n_of(od, 1));
      m_exc  = sat(m_exc + n_of(ev, 2) + n_of(od, 2));
    end
  endtask

  task automatic check_all();
    check("valid", vld, mq.size() > 0);
    if (mq.size() > 0) begin
      check("data", dat, mq[0].d);
      check("type", typ, mq[0].t);
      check("stamp", stp, mq[0].s);
      check("err", err, mq[0].e);
    end
    check("busy", busy, m_rem > 0);
    check("ovf", ovf, m_ovf);
    check("inst", icnt, m_inst);
    check("br", bcnt, m_br);
    check("exc", xcnt, m_exc);
  endtask

  task automatic step();
    if (rnd) begin
      ev   = 2'($urandom);
      od   = 2'($urandom);
      oc   = 1'($urandom);
      rdy  = 1'($urandom);
      clr  = ($urandom_range(0, 63) == 0);
      rstn = ($urandom_range(0, 399) != 0);
    end
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send_pkt(input logic [1:0]  t,
                          input logic [31:0] d,
                          input logic [11:0] s,
                          input bit          rdy_last);
    logic [47:0] w;
    w = {1'b1, t, 1'b0, d, s};
    for (int i = 0; i < 12; i++) begin
      ts = w[47-4*i -: 4];
      if (rdy_last && i == 11) rdy = 1'b1;
      step();
      if (rdy_last) rdy = 1'b0;
    end
    ts = '0;
  endtask

  task automatic drain();
    rdy = 1'b1;
    for (int i = 0; i < 20 && mq.size() > 0; i++) step();
    rdy = 1'b0;
    check("drained", vld, 1'b0);
  endtask

  logic [29:0] pv [5];

  initial begin
    n_chk = 0;
    n_pass = 0;
    rnd  = 0;
    rstn = 1'b0;
    ts   = '0;
    ev   = '0;
    od   = '0;
    oc   = 1'b0;
    clr  = 1'b0;
    rdy  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", vld, 1'b0);
    check("rst_data", dat, 30'h0);
    check("rst_type", typ, 2'b00);
    check("rst_stamp", stp, 9'h0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_cnt", {icnt, bcnt, xcnt}, 48'h0);
    rstn = 1'b1;
    step();

    // single packet, header then 12-cycle latency
    send_pkt(2'b10, {30'h2AAA5555, 2'b00}, 12'h1F3, 0);
    check("p1_valid", vld, 1'b1);
    check("p1_data", dat, 30'h2AAA5555);
    check("p1_type", typ, 2'b10);
    check("p1_stamp", stp, 9'h1F3);
    check("p1_err", err, 1'b0);
    drain();

    send_pkt(2'b10, {30'h2AAA5555, 2'b01}, 12'h1F3, 0);
    check("pad_d_err", err, 1'b1);
    check("pad_d_data", dat, 30'h2AAA5555);
    drain();
    send_pkt(2'b10, {30'h2AAA5555, 2'b00}, 12'h8F3, 0);
    check("pad_s_err", err, 1'b1);
    check("pad_s_stamp", stp, 9'h0F3);
    drain();

    // overflow with consumer stalled
    pv[0] = 30'h0123_4567;
    pv[1] = 30'h1111_2222;
    pv[2] = 30'h2FED_CBA9;
    pv[3] = 30'h0F0F_0F0F;
    pv[4] = 30'h3333_3333;
    for (int i = 0; i < 5; i++)
      send_pkt(2'(i), {pv[i], 2'b00}, 12'(i + 1), 0);
    check("ovf_set", ovf, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("ovf_clr", ovf, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("ovf_pop", dat, pv[i]);
      rdy = 1'b1;
      step();
      rdy = 1'b0;
    end
    check("ovf_empty", vld, 1'b0);

    // full FIFO with a pop in the cycle the fifth record lands
    for (int i = 0; i < 4; i++)
      send_pkt(2'(i), {pv[i], 2'b00}, 12'(i + 1), 0);
    send_pkt(2'b11, {pv[4], 2'b00}, 12'h005, 1);
    check("fp_ovf", ovf, 1'b0);
    for (int i = 1; i < 5; i++) begin
      check("fp_pop", dat, pv[i]);
      rdy = 1'b1;
      step();
      rdy = 1'b0;
    end
    check("fp_empty", vld, 1'b0);

    // ES counting, saturation, clear-wins
    clr = 1'b1;
    step();
    clr = 1'b0;
    oc = 1'b1;
    ev = 2'b10;
    od = 2'b11;
    repeat (3) step();
    oc = 1'b0;
    check("es_inst", icnt, 16'd3);
    check("es_br", bcnt, 16'd3);
    check("es_exc", xcnt, 16'd3);
    oc = 1'b1;
    ev = 2'b01;
    od = 2'b01;
    repeat (32770) step();
    check("sat_inst", icnt, 16'hFFFF);
    check("sat_br", bcnt, 16'd3);
    ev = 2'b10;
    od = 2'b11;
    clr = 1'b1;
    step();
    clr = 1'b0;
    oc = 1'b0;
    check("clr_cnt", {icnt, bcnt, xcnt}, 48'h0);

    // reset in the middle of a packet
    begin
      logic [47:0] w;
      w = {1'b1, 2'b01, 1'b0, 32'hDEAD_BEEC, 12'h0AB};
      for (int i = 0; i < 6; i++) begin
        ts = w[47-4*i -: 4];
        if (i == 5) rstn = 1'b0;
        step();
      end
      rstn = 1'b1;
      ts = '0;
      check("mr_busy", busy, 1'b0);
      check("mr_valid", vld, 1'b0);
    end
    send_pkt(2'b01, {30'h1234_5678, 2'b00}, 12'h0AB, 0);
    check("mr_data", dat, 30'h1234_5678);
    check("mr_stamp", stp, 9'h0AB);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    check("mr_one", vld, 1'b0);

    // randomized traffic
    rnd = 1;
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [31:0] d;
        logic [11:0] s;
        d = $urandom;
        s = 12'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          d[1:0]  = 2'b00;
          s[11:9] = 3'b000;
        end
        send_pkt(2'($urandom), d, s, 0);
      end else begin
        for (int j = 0; j < 3; j++) begin
          ts = 4'($urandom);
          step();
        end
        ts = '0;
      end
    end
    rnd = 0;
    rstn = 1'b1;
    clr = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
